// File: rtl/note_ctrl_pkg.sv
// note_ctrl_pkg
// Shared types and widths for the note envelope controller.
//   TUNE_W      : width of the tuning word sent to the wave generator
//   VOL_W       : width of the unsigned volume sent to the multiplier
//   noteState_t : envelope FSM state, also exported on the state port
package note_ctrl_pkg;

    localparam int TUNE_W = 16;
    localparam int VOL_W  = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RAMP    = 2'd1,
        SUSTAIN = 2'd2,
        RELEASE = 2'd3
    } noteState_t;

endpackage

// File: rtl/env_ramp.sv
// env_ramp
// Combinational saturating step of a volume toward a target. The step is
// computed in VOL_W+1 bits so it can neither wrap below 0 nor above 255, and
// it lands exactly on the target instead of overshooting it.
// Ports:
//   volCur    in  VOL_W  current volume
//   volTarget in  VOL_W  volume being approached
//   volNext   out VOL_W  volume after one step of STEP toward volTarget
module env_ramp
    import note_ctrl_pkg::*;
#(
    parameter int unsigned STEP = 4
) (
    input  logic [VOL_W-1:0] volCur,
    input  logic [VOL_W-1:0] volTarget,
    output logic [VOL_W-1:0] volNext
);

    localparam logic [VOL_W:0] STEP_EXT = STEP[VOL_W:0];

    logic [VOL_W:0] curExt;
    logic [VOL_W:0] tgtExt;
    logic [VOL_W:0] upExt;
    logic [VOL_W:0] downExt;

    always_comb begin
        curExt  = {1'b0, volCur};
        tgtExt  = {1'b0, volTarget};
        upExt   = curExt + STEP_EXT;
        downExt = curExt - STEP_EXT;
        volNext = volCur;
        if (curExt < tgtExt) begin
            volNext = (upExt >= tgtExt) ? volTarget : upExt[VOL_W-1:0];
        end else if (curExt > tgtExt) begin
            // Only subtract when the gap exceeds the step, so downExt never wraps.
            volNext = ((curExt - tgtExt) <= STEP_EXT) ? volTarget : downExt[VOL_W-1:0];
        end
    end

endmodule

// File: rtl/note_env_ctrl.sv
// note_env_ctrl
// Note envelope controller: accepts note requests, ramps the output volume
// toward the requested level on each tick, releases to silence before a
// tuning change, and holds one pending note while releasing.
// Ports:
//   clk        in   1      system clock
//   reset      in   1      synchronous active-low reset
//   tick       in   1      one-cycle strobe pacing every volume step
//   req_valid  in   1      note request present
//   req_ready  out  1      low only while the pending buffer is occupied
//   req_tune   in   TUNE_W requested tuning word (0 = note-off)
//   req_vol    in   VOL_W  requested target volume (0 = note-off)
//   tune_word  out  TUNE_W tuning word to the wave generator
//   volume     out  VOL_W  volume to the multiplier
//   state      out  2      current FSM state
// Build option: define NOTE_ENV_CTRL_WDT_EN to add a watchdog that forces a
// release after WDT_TICKS ticks without an accepted request.
//
// state   | meaning
// IDLE    | silent, tune_word 0, waiting for a note-on
// RAMP    | stepping volume toward target by ATTACK_STEP per tick
// SUSTAIN | volume at target, held
// RELEASE | stepping volume to 0 by RELEASE_STEP, then pending note or IDLE
module note_env_ctrl
    import note_ctrl_pkg::*;
#(
    parameter int unsigned ATTACK_STEP  = 4,
    parameter int unsigned RELEASE_STEP = 2,
    parameter int unsigned WDT_TICKS    = 524288
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [TUNE_W-1:0] req_tune,
    input  logic [VOL_W-1:0]  req_vol,
    output logic [TUNE_W-1:0] tune_word,
    output logic [VOL_W-1:0]  volume,
    output logic [1:0]        state
);

    noteState_t        stateQ, stateD;
    logic [TUNE_W-1:0] tuneQ, tuneD;
    logic [VOL_W-1:0]  volQ, volD;
    logic [VOL_W-1:0]  targetQ, targetD;
    logic              pendQ, pendD;
    logic [TUNE_W-1:0] pendTuneQ, pendTuneD;
    logic [VOL_W-1:0]  pendVolQ, pendVolD;

    logic [VOL_W-1:0]  attackNext;
    logic [VOL_W-1:0]  releaseNext;
    logic              accept;
    logic              noteOff;
    logic              wdtExpired;

    assign accept  = req_valid & req_ready;
    assign noteOff = (req_tune == '0) || (req_vol == '0);

    env_ramp #(.STEP(ATTACK_STEP)) attackRamp (
        .volCur    (volQ),
        .volTarget (targetQ),
        .volNext   (attackNext)
    );

    env_ramp #(.STEP(RELEASE_STEP)) releaseRamp (
        .volCur    (volQ),
        .volTarget ('0),
        .volNext   (releaseNext)
    );

`ifdef NOTE_ENV_CTRL_WDT_EN
    localparam int WDT_W = $clog2(WDT_TICKS + 1);
    localparam logic [WDT_W-1:0] WDT_LIMIT = WDT_W'(WDT_TICKS);

    logic [WDT_W-1:0] wdtQ;

    // Saturates at the limit so an expired watchdog stays expired until the
    // next accepted request.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wdtQ <= '0;
        end else if (accept) begin
            wdtQ <= '0;
        end else if (tick && (wdtQ != WDT_LIMIT)) begin
            wdtQ <= wdtQ + 1'b1;
        end
    end

    assign wdtExpired = (wdtQ == WDT_LIMIT);
`else
    logic [31:0] unusedWdtTicks;
    assign unusedWdtTicks = WDT_TICKS;
    assign wdtExpired     = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            stateQ    <= IDLE;
            tuneQ     <= '0;
            volQ      <= '0;
            targetQ   <= '0;
            pendQ     <= 1'b0;
            pendTuneQ <= '0;
            pendVolQ  <= '0;
        end else begin
            stateQ    <= stateD;
            tuneQ     <= tuneD;
            volQ      <= volD;
            targetQ   <= targetD;
            pendQ     <= pendD;
            pendTuneQ <= pendTuneD;
            pendVolQ  <= pendVolD;
        end
    end

    // Priority: accepted request, then watchdog, then tick-paced stepping.
    // A tick coinciding with an accept is therefore dropped.
    always_comb begin
        stateD    = stateQ;
        tuneD     = tuneQ;
        volD      = volQ;
        targetD   = targetQ;
        pendD     = pendQ;
        pendTuneD = pendTuneQ;
        pendVolD  = pendVolQ;

        if (accept) begin
            case (stateQ)
                IDLE: begin
                    if (!noteOff) begin
                        tuneD   = req_tune;
                        targetD = req_vol;
                        stateD  = RAMP;
                    end
                end
                RAMP, SUSTAIN: begin
                    if (noteOff) begin
                        stateD = RELEASE;
                    end else if (req_tune == tuneQ) begin
                        targetD = req_vol;
                        stateD  = RAMP;
                    end else begin
                        pendD     = 1'b1;
                        pendTuneD = req_tune;
                        pendVolD  = req_vol;
                        stateD    = RELEASE;
                    end
                end
                RELEASE: begin
                    if (noteOff) begin
                        pendD = 1'b0;
                    end else begin
                        pendD     = 1'b1;
                        pendTuneD = req_tune;
                        pendVolD  = req_vol;
                    end
                end
                default: ;
            endcase
        end else if (wdtExpired && ((stateQ == RAMP) || (stateQ == SUSTAIN))) begin
            stateD = RELEASE;
            pendD  = 1'b0;
        end else begin
            case (stateQ)
                RAMP: begin
                    if (tick) begin
                        volD = attackNext;
                        if (attackNext == targetQ) begin
                            stateD = SUSTAIN;
                        end
                    end
                end
                RELEASE: begin
                    // Tune only moves once the volume register is already 0.
                    if (volQ == '0) begin
                        if (pendQ) begin
                            tuneD   = pendTuneQ;
                            targetD = pendVolQ;
                            pendD   = 1'b0;
                            stateD  = RAMP;
                        end else begin
                            tuneD  = '0;
                            stateD = IDLE;
                        end
                    end else if (tick) begin
                        volD = releaseNext;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready = ~pendQ;
    assign tune_word = tuneQ;
    assign volume    = volQ;
    assign state     = stateQ;

endmodule

// File: doc/note_env_ctrl.md
NOTE_ENV_CTRL -- requirements
Module: note_env_ctrl

Interface
REQ-001 Parameter ATTACK_STEP, 4, volume increment/decrement per tick while ramping toward target.
REQ-002 Parameter RELEASE_STEP, 2, volume decrement per tick while releasing.
REQ-003 Parameter WDT_TICKS, 524288, ticks without an accepted request before forced release (~3.36 s at 156.25 kHz).
REQ-004 clk  in  1  system clock (40 MHz); single clock domain.
REQ-005 reset  in  1  synchronous, active-low reset; reset==0 at a clk edge resets the block.
REQ-006 tick  in  1  one-cycle sample strobe (once per 256 clk); paces all volume ramps.
REQ-007 req_valid  in  1  note request present.
REQ-008 req_ready  out  1  block can accept a request.
REQ-009 req_tune  in  16  requested tuning word; 0 = note-off.
REQ-010 req_vol  in  8  requested target volume; 0 = note-off.
REQ-011 tune_word  out  16  tuning word driven to the wave generator.
REQ-012 volume  out  8  unsigned volume driven to the multiplier.
REQ-013 state  out  2  current FSM state (debug/status).

Function
REQ-014 FSM states SHALL be IDLE, RAMP, SUSTAIN, RELEASE; all outputs registered.
REQ-015 A request SHALL be accepted in a cycle with req_valid & req_ready; accepted values take effect on the next clk edge.
REQ-016 req_ready SHALL be 1 except when the one-entry pending buffer is full.
REQ-017 Note-off (req_tune==0 or req_vol==0): IDLE -> no change; RAMP/SUSTAIN -> RELEASE; RELEASE -> clears any pending entry.
REQ-018 Note-on in IDLE: tune_word <= req_tune, target <= req_vol, volume stays 0, -> RAMP.
REQ-019 Note-on in RAMP/SUSTAIN with req_tune==tune_word: target <= req_vol, -> RAMP (no release).
REQ-020 Note-on in RAMP/SUSTAIN with different tune: store in pending buffer, -> RELEASE.
REQ-021 Note-on in RELEASE: store in pending buffer (ready low afterwards until consumed).
REQ-022 RAMP on tick: volume moves toward target by ATTACK_STEP, saturating exactly at target; volume==target -> SUSTAIN.
REQ-023 SUSTAIN: volume and tune_word held.
REQ-024 RELEASE on tick: volume <= (volume > RELEASE_STEP) ? volume-RELEASE_STEP : 0.
REQ-025 When RELEASE reaches volume 0: pending valid -> load pending tune/target, clear pending, -> RAMP; else tune_word <= 0, -> IDLE.
REQ-026 Accept and tick in the same cycle: the request-driven transition wins; that tick's volume step is skipped.
REQ-027 Volume arithmetic SHALL be 9-bit internally; never wraps below 0 or above 255.
REQ-028 tune_word SHALL change only while volume==0.

Reset
REQ-029 On reset: state=IDLE, tune_word=0, volume=0, target=0, pending cleared, req_ready=1, watchdog=0.
REQ-030 Reset mid-ramp or mid-release SHALL zero volume immediately, no ramp-down.

Configuration
REQ-031 Macro NOTE_ENV_CTRL_WDT_EN defined: tick counter cleared on every accept; reaching WDT_TICKS in RAMP/SUSTAIN forces RELEASE with pending cleared.
REQ-032 Macro undefined: no watchdog counter; notes sustain indefinitely; WDT_TICKS unused.

Structure
REQ-033 Package note_ctrl_pkg SHALL hold the state enum, TUNE_W=16, VOL_W=8.
REQ-034 Sub-module env_ramp SHALL implement the saturating step-toward-target for volume; FSM and handshake stay in note_env_ctrl.

Verification
REQ-035 IDLE, req tune=0x0400 vol=200 -> tune_word=0x0400 next cycle; volume=200 after 50 ticks; state SUSTAIN.
REQ-036 SUSTAIN vol 200, req tune=0x0800 vol=100 -> RELEASE, req_ready=0; volume 0 after 100 ticks; then tune_word=0x0800, RAMP to 100 in 25 ticks.
REQ-037 SUSTAIN tune=0x0400 vol 200, req tune=0x0400 vol=50 -> RAMP down, volume=50 after 38 ticks (last step saturates), no tune change.
REQ-038 Request accepted on same cycle as tick in SUSTAIN -> volume unchanged that tick, state RAMP/RELEASE next cycle.
REQ-039 reset=0 mid-RAMP at volume 120 -> next cycle volume=0, tune_word=0, IDLE, req_ready=1.
REQ-040 NOTE_ENV_CTRL_WDT_EN, WDT_TICKS=16, SUSTAIN, no requests -> RELEASE after tick 16, IDLE with tune_word=0 at volume 0; macro undefined -> SUSTAIN held.
